gba_raster_mapper: RTL and testbench

Parametrised successor to the fixed-scale raster mapping inside the video output path. It sits between the HDMI core's raster counters (cx/cy) and the line cache. It maps a SRC_W×SRC_H source image into the active area at a runtime-selectable integer scale, and generates pixel and line read requests plus phase indices for the grid and smoothing units. It frame-locks the HDMI raster to the source frame start, and detects and recovers from loss of lock.

---
 rtl/gba_raster_mapper.sv | 181 ++++++++++++++++++
 tb/tb_gba_raster_mapper.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gba_raster_mapper.sv
// Maps a SRC_W x SRC_H source into the HDMI active area at an integer scale and frame-locks the raster.
// Optional scanline output is enabled by defining GBA_RASTER_SCANLINE_EN.
module gba_raster_mapper #(
  parameter int SRC_W     = 240,
  parameter int SRC_H     = 160,
  parameter int ACT_W     = 1280,
  parameter int ACT_H     = 720,
  parameter int TOT_W     = 1650,
  parameter int TOT_H     = 750,
  parameter int MAX_SCALE = 4,
  parameter int REQ_OFS   = 8,
  parameter int LOCK_TOL  = 2
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic [2:0]  scaleSel,
  input  logic        newFrameIn,
  input  logic        sameLine,
  output logic        drawWin,
  output logic [7:0]  pxlRd,
  output logic [2:0]  xPhase,
  output logic [2:0]  yPhase,
  output logic        nextLine,
  output logic        cacheUpdate,
  output logic        setStart,
  output logic [11:0] setStartX,
  output logic [10:0] setStartY,
  output logic        locked
`ifdef GBA_RASTER_SCANLINE_EN
  ,
  output logic        scanline
`endif
);

  if (MAX_SCALE * SRC_W > ACT_W || MAX_SCALE * SRC_H > ACT_H) begin : g_bad_scale
    $error("gba_raster_mapper: MAX_SCALE does not fit the active area");
  end

  typedef enum logic [1:0] {UNLOCK, SYNC, LOCKED} state_t;

  function automatic logic [2:0] clamp_scale(input logic [2:0] sel);
    logic [3:0] s;
    s = {1'b0, sel} + 4'd1;
    if (s > 4'(MAX_SCALE)) return 3'(MAX_SCALE);
    return s[2:0];
  endfunction

  function automatic logic [11:0] x_start(input logic [2:0] s);
    return 12'((ACT_W - int'(s) * SRC_W) / 2);
  endfunction

  function automatic logic [10:0] y_start(input logic [2:0] s);
    return 11'((ACT_H - int'(s) * SRC_H) / 2);
  endfunction

  state_t      state;
  logic [2:0]  scl;
  logic [2:0]  scl_req;
  logic [11:0] cx_d;
  logic [10:0] cy_d;
  logic        nf_d;

  logic [11:0] xs;
  logic [11:0] x_end;
  logic [10:0] ys;
  logic [10:0] y_end;
  logic [10:0] ys_req;
  logic        in_win;
  logic        line_end;
  logic        frame_end;
  logic        nf_rise;
  logic        last_sub;
  logic        req_pt;
  int          lock_err;
  logic        too_far;

  assign scl_req   = clamp_scale(scaleSel);
  assign xs        = x_start(scl);
  assign ys        = y_start(scl);
  assign x_end     = 12'(int'(xs) + int'(scl) * SRC_W);
  assign y_end     = 11'(int'(ys) + int'(scl) * SRC_H);
  assign ys_req    = y_start(scl_req);
  assign in_win    = (cx >= xs) && (cx < x_end) && (cy >= ys) && (cy < y_end);
  assign line_end  = (cx == 12'(TOT_W - 1));
  assign frame_end = line_end && (cy == 11'(TOT_H - 1));
  assign nf_rise   = newFrameIn & ~nf_d;
  assign last_sub  = (yPhase == scl - 3'd1);
  assign req_pt    = (cx_d == 12'(TOT_W - REQ_OFS));

  assign cacheUpdate = req_pt;
  assign nextLine    = req_pt && !sameLine && (state != SYNC) && (cy >= ys) && last_sub;

  always_comb begin
    lock_err = int'(cy) - (int'(ys) - 2);
    too_far  = (lock_err > LOCK_TOL) || (lock_err < -LOCK_TOL);
  end

  always_ff @(posedge pxlClk) begin
    // Sampled through reset so a level held high across reset is not seen as an edge.
    nf_d <= newFrameIn;
    if (rst) begin
      state     <= UNLOCK;
      scl       <= scl_req;
      cx_d      <= '0;
      cy_d      <= '0;
      drawWin   <= 1'b0;
      pxlRd     <= '0;
      xPhase    <= '0;
      yPhase    <= '0;
      setStart  <= 1'b0;
      setStartX <= '0;
      setStartY <= '0;
      locked    <= 1'b0;
`ifdef GBA_RASTER_SCANLINE_EN
      scanline  <= 1'b0;
`endif
    end else begin
      cx_d    <= cx;
      cy_d    <= cy;
      drawWin <= in_win;

      // drawWin still holds the previous pixel's window flag, marking the first pixel of a run.
      if (in_win && drawWin) begin
        if (xPhase == scl - 3'd1) begin
          xPhase <= '0;
          if (pxlRd != 8'(SRC_W - 1)) pxlRd <= pxlRd + 8'd1;
        end else begin
          xPhase <= xPhase + 3'd1;
        end
      end else begin
        xPhase <= '0;
        pxlRd  <= '0;
      end

      if (line_end) begin
        if (cy == 11'(TOT_H - 1) || state == SYNC) yPhase <= '0;
        else if (last_sub)                         yPhase <= '0;
        else if (cy >= ys)                         yPhase <= yPhase + 3'd1;
      end

`ifdef GBA_RASTER_SCANLINE_EN
      scanline <= in_win && last_sub && (scl >= 3'd2);
`endif

      if (frame_end) scl <= scl_req;

      case (state)
        UNLOCK: begin
          if (nf_rise) begin
            state     <= SYNC;
            setStart  <= 1'b1;
            setStartX <= '0;
            setStartY <= 11'(int'(ys_req) - 2);
            scl       <= scl_req;
          end
        end
        SYNC: begin
          if (cy != cy_d) begin
            state    <= LOCKED;
            setStart <= 1'b0;
            locked   <= 1'b1;
          end
        end
        LOCKED: begin
          if (nf_rise && too_far) begin
            state     <= SYNC;
            locked    <= 1'b0;
            setStart  <= 1'b1;
            setStartX <= '0;
            setStartY <= 11'(int'(ys_req) - 2);
            scl       <= scl_req;
          end
        end
        default: state <= UNLOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_raster_mapper.sv
// Directed bench for gba_raster_mapper: window geometry, counters, line requests and lock behaviour.
module tb_gba_raster_mapper;

  logic        pxlClk = 1'b0;
  logic        rst;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [2:0]  scaleSel;
  logic        newFrameIn;
  logic        sameLine;
  logic        drawWin;
  logic [7:0]  pxlRd;
  logic [2:0]  xPhase;
  logic [2:0]  yPhase;
  logic        nextLine;
  logic        cacheUpdate;
  logic        setStart;
  logic [11:0] setStartX;
  logic [10:0] setStartY;
  logic        locked;
`ifdef GBA_RASTER_SCANLINE_EN
  logic        scanline;
`endif

  gba_raster_mapper dut (
    .pxlClk(pxlClk), .rst(rst), .cx(cx), .cy(cy), .scaleSel(scaleSel),
    .newFrameIn(newFrameIn), .sameLine(sameLine), .drawWin(drawWin), .pxlRd(pxlRd),
    .xPhase(xPhase), .yPhase(yPhase), .nextLine(nextLine), .cacheUpdate(cacheUpdate),
    .setStart(setStart), .setStartX(setStartX), .setStartY(setStartY), .locked(locked)
`ifdef GBA_RASTER_SCANLINE_EN
    , .scanline(scanline)
`endif
  );

  always #5 pxlClk = ~pxlClk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int draw;
    int rd;
    int ph;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic drive(input int x, input int y);
    cx = 12'(x);
    cy = 11'(y);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_drawWin"}, int'(drawWin), 0);
    check({tag, "_pxlRd"}, int'(pxlRd), 0);
    check({tag, "_xPhase"}, int'(xPhase), 0);
    check({tag, "_yPhase"}, int'(yPhase), 0);
    check({tag, "_nextLine"}, int'(nextLine), 0);
    check({tag, "_cacheUpdate"}, int'(cacheUpdate), 0);
    check({tag, "_setStart"}, int'(setStart), 0);
    check({tag, "_setStartX"}, int'(setStartX), 0);
    check({tag, "_setStartY"}, int'(setStartY), 0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic win_at(input string name, input int x, input int y, input int exp);
    drive(x, y);
    step();
    check(name, int'(drawWin), exp);
  endtask

  initial begin
    // Scale 4 row cy=40: xS=160, window ends after cx=1119, pxlRd steps every 4 pixels
    vecs[0] = '{159, 0, 0, 0};
    vecs[1] = '{160, 1, 0, 0};
    vecs[2] = '{161, 1, 0, 1};
    vecs[3] = '{163, 1, 0, 3};
    vecs[4] = '{164, 1, 1, 0};
    vecs[5] = '{500, 1, 85, 0};
    vecs[6] = '{1115, 1, 238, 3};
    vecs[7] = '{1116, 1, 239, 0};
    vecs[8] = '{1119, 1, 239, 3};
    vecs[9] = '{1120, 0, 0, 0};

    rst = 1'b1; scaleSel = 3'd3; newFrameIn = 1'b0; sameLine = 1'b0;
    drive(0, 0);
    step(); step();
    check_zero("reset");

    // Initial lock: yS=40 at scale 4, so forced row is 38
    rst = 1'b0;
    drive(5, 100);
    step();
    check("unlock_idle", int'(locked), 0);
    newFrameIn = 1'b1;
    step();
    check("sync_setStart", int'(setStart), 1);
    check("sync_setStartX", int'(setStartX), 0);
    check("sync_setStartY", int'(setStartY), 38);
    check("sync_locked", int'(locked), 0);
    drive(0, 38);
    step();
    check("lock_locked", int'(locked), 1);
    check("lock_setStart", int'(setStart), 0);

    for (int x = 150; x <= 1130; x++) begin
      drive(x, 40);
      step();
      foreach (vecs[i]) begin
        if (vecs[i].x == x) begin
          check($sformatf("row40_draw_%0d", x), int'(drawWin), vecs[i].draw);
          check($sformatf("row40_rd_%0d", x), int'(pxlRd), vecs[i].rd);
          check($sformatf("row40_ph_%0d", x), int'(xPhase), vecs[i].ph);
        end
      end
    end
    check("row40_yPhase", int'(yPhase), 0);

    // Line requests: cacheUpdate every line, nextLine only on last sub-line
    drive(1642, 40);
    step();
    check("cu_ph0", int'(cacheUpdate), 1);
    check("nl_ph0", int'(nextLine), 0);
    drive(1643, 40);
    step();
    check("cu_after", int'(cacheUpdate), 0);
    for (int y = 40; y <= 42; y++) begin
      drive(1649, y);
      step();
    end
    check("yPhase_3", int'(yPhase), 3);
    sameLine = 1'b1;
    drive(1642, 43);
    step();
    check("cu_sameLine", int'(cacheUpdate), 1);
    check("nl_sameLine", int'(nextLine), 0);
    sameLine = 1'b0;
    #1;
    check("nl_fire", int'(nextLine), 1);
    drive(1649, 43);
    step();
    check("yPhase_wrap", int'(yPhase), 0);
    check("cu_line_end", int'(cacheUpdate), 0);

    // Mid-frame scale change is deferred to the next frame
    scaleSel = 3'd1;
    win_at("mid_x159", 159, 50, 0);
    win_at("mid_x160", 160, 50, 1);
    drive(1649, 749);
    step();
    win_at("s2_top_out", 400, 199, 0);
    win_at("s2_x399", 399, 200, 0);
    win_at("s2_x400", 400, 200, 1);
    check("s2_rd400", int'(pxlRd), 0);
    check("s2_ph400", int'(xPhase), 0);
    drive(401, 200); step();
    check("s2_ph401", int'(xPhase), 1);
    check("s2_rd401", int'(pxlRd), 0);
    drive(402, 200); step();
    check("s2_ph402", int'(xPhase), 0);
    check("s2_rd402", int'(pxlRd), 1);
    drive(403, 200); step();
    drive(404, 200); step();
    check("s2_rd404", int'(pxlRd), 2);
    check("s2_yPhase", int'(yPhase), 0);
    win_at("s2_x879", 879, 519, 1);
    win_at("s2_x880", 880, 519, 0);
    win_at("s2_bottom_out", 400, 520, 0);

    // scaleSel=7 clamps to 4
    scaleSel = 3'd7;
    drive(1649, 749);
    step();
    win_at("clamp_x159", 159, 40, 0);
    win_at("clamp_x160", 160, 40, 1);
    drive(161, 40); step();
    check("clamp_ph161", int'(xPhase), 1);
    win_at("clamp_y39", 160, 39, 0);
    win_at("clamp_y679", 160, 679, 1);
    win_at("clamp_y680", 160, 680, 0);

    // Lock tolerance around target row 38
    newFrameIn = 1'b0; drive(10, 40); step();
    newFrameIn = 1'b1; step();
    check("tol_p2_locked", int'(locked), 1);
    check("tol_p2_setStart", int'(setStart), 0);
    newFrameIn = 1'b0; drive(10, 36); step();
    newFrameIn = 1'b1; step();
    check("tol_m2_locked", int'(locked), 1);
    newFrameIn = 1'b0; drive(10, 40); step();
    newFrameIn = 1'b1; drive(10, 41); step();
    check("tol_p3_locked", int'(locked), 0);
    check("tol_p3_setStart", int'(setStart), 1);
    check("tol_p3_setStartY", int'(setStartY), 38);
    step();
    check("tol_hold_setStart", int'(setStart), 1);
    check("tol_hold_locked", int'(locked), 0);
    drive(0, 38); step();
    check("tol_relock", int'(locked), 1);
    check("tol_relock_setStart", int'(setStart), 0);
    newFrameIn = 1'b0; step();
    newFrameIn = 1'b1; drive(10, 35); step();
    check("tol_m3_locked", int'(locked), 0);
    drive(0, 38); step();
    check("tol_m3_relock", int'(locked), 1);

    // Reset while locked mid-frame, then relock
    newFrameIn = 1'b0;
    drive(500, 300); step();
    check("pre_reset_draw", int'(drawWin), 1);
    rst = 1'b1; step();
    check_zero("midrst");
    rst = 1'b0; step();
    check("post_rst_locked", int'(locked), 0);
    check("post_rst_setStart", int'(setStart), 0);
    newFrameIn = 1'b1; step();
    check("post_rst_sync", int'(setStart), 1);
    check("post_rst_setStartY", int'(setStartY), 38);
    drive(0, 38); step();
    check("post_rst_relock", int'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
